core_mem_arbiter: RTL and testbench

Shares one downstream memory port between the core's instruction-fetch (imem) and load/store (dmem) requesters. All three interfaces use the same req/gnt protocol:
- Address phase completes on req && gnt.
- Response (rdata, err) arrives exactly one cycle later.
Sits between the core and the single-ported memory / MMIO fabric. Uses fixed priority plus anti-starvation promotion, locks the selection while a request is pending, and steers each response back to its owner.

---
 rtl/core_mem_arbiter.sv | 107 ++++++++++
 tb/tb_core_mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Two-into-one memory port arbiter: imem and dmem share one req/gnt downstream port.
// Fixed priority with anti-starvation promotion, selection locked while a request is stalled.
module core_mem_arbiter #(
  parameter int MEM_ADDR_W    = 64,
  parameter int MEM_DATA_W    = 64,
  parameter int PRIORITY_DMEM = 1,
  parameter int MAX_STARVE    = 4
) (
  input  logic                    g_clk,
  input  logic                    g_resetn,
  input  logic                    imem_req,
  input  logic [MEM_ADDR_W-1:0]   imem_addr,
  input  logic                    imem_wen,
  input  logic [MEM_DATA_W/8-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0]   imem_wdata,
  output logic                    imem_gnt,
  output logic                    imem_err,
  output logic [MEM_DATA_W-1:0]   imem_rdata,
  input  logic                    dmem_req,
  input  logic [MEM_ADDR_W-1:0]   dmem_addr,
  input  logic                    dmem_wen,
  input  logic [MEM_DATA_W/8-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0]   dmem_wdata,
  output logic                    dmem_gnt,
  output logic                    dmem_err,
  output logic [MEM_DATA_W-1:0]   dmem_rdata,
  output logic                    mem_req,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [MEM_DATA_W/8-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_err,
  input  logic [MEM_DATA_W-1:0]   mem_rdata,
  output logic                    arb_sel
);

  localparam int              CNT_W      = $clog2(MAX_STARVE + 1);
  localparam logic            HI_SEL     = (PRIORITY_DMEM != 0);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

  logic             lock_p1;
  logic             lock_sel_p1;
  logic             resp_vld_p1;
  logic             resp_sel_p1;
  logic [CNT_W-1:0] starve_cnt;

  logic sel;
  logic sel_req;
  logic lo_req;
  logic accept;
  logic resp_on;

  // Stage 0: selection, forwarding and grant (all combinational)
  always_comb begin
    sel = HI_SEL;
    if (lock_p1)
      sel = lock_sel_p1;
    else if (imem_req ^ dmem_req)
      sel = dmem_req;
    else if (imem_req && dmem_req && (starve_cnt >= STARVE_MAX))
      sel = ~HI_SEL;
  end

  assign lo_req  = HI_SEL ? imem_req : dmem_req;
  assign sel_req = sel ? dmem_req : imem_req;

  assign mem_req   = g_resetn && sel_req;
  assign mem_addr  = sel ? dmem_addr  : imem_addr;
  assign mem_wen   = sel ? dmem_wen   : imem_wen;
  assign mem_strb  = sel ? dmem_strb  : imem_strb;
  assign mem_wdata = sel ? dmem_wdata : imem_wdata;

  assign accept   = mem_req && mem_gnt;
  assign imem_gnt = accept && !sel;
  assign dmem_gnt = accept && sel;
  assign arb_sel  = g_resetn ? sel : HI_SEL;

  // Stage 0 -> 1: lock, response ownership and starvation tracking
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock_p1     <= 1'b0;
      lock_sel_p1 <= 1'b0;
      resp_vld_p1 <= 1'b0;
      resp_sel_p1 <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      // A dropped locked req gives mem_req=0, so this also releases the lock.
      lock_p1     <= mem_req && !mem_gnt;
      lock_sel_p1 <= sel;
      resp_vld_p1 <= accept;
      resp_sel_p1 <= sel;
      if (!lo_req || (accept && (sel != HI_SEL)))
        starve_cnt <= '0;
      else if (accept && (sel == HI_SEL) && (starve_cnt != STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Stage 1: response steering back to the owner of the previous accept
  assign resp_on    = g_resetn && resp_vld_p1;
  assign imem_rdata = (resp_on && !resp_sel_p1) ? mem_rdata : '0;
  assign dmem_rdata = (resp_on &&  resp_sel_p1) ? mem_rdata : '0;
  assign imem_err   = resp_on && !resp_sel_p1 && mem_err;
  assign dmem_err   = resp_on &&  resp_sel_p1 && mem_err;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: priority, lock, starvation, response steering, reset.
module tb_core_mem_arbiter;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_req, imem_wen, imem_gnt, imem_err;
  logic [63:0] imem_addr, imem_wdata, imem_rdata;
  logic [7:0]  imem_strb;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;
  logic        mem_req, mem_wen, mem_gnt, mem_err, arb_sel;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_strb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 g_clk = ~g_clk;

  core_mem_arbiter #(.MEM_ADDR_W(64), .MEM_DATA_W(64), .PRIORITY_DMEM(1), .MAX_STARVE(4)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .arb_sel(arb_sel)
  );

  // One cycle of stimulus: inputs change 1 time unit after the edge, outputs settle 1 unit later.
  task automatic drv(input logic rn, input logic ir, input logic [63:0] ia,
                     input logic dr, input logic [63:0] da, input logic g,
                     input logic [63:0] rd, input logic e);
    @(posedge g_clk); #1;
    g_resetn = rn; imem_req = ir; imem_addr = ia; dmem_req = dr; dmem_addr = da;
    mem_gnt = g; mem_rdata = rd; mem_err = e;
    #1;
  endtask

  task automatic idle();
    drv(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic test_reset();
    drv(1'b0, 1'b1, 64'h10, 1'b1, 64'h20, 1'b1, 64'h5555, 1'b1);
    drv(1'b0, 1'b1, 64'h10, 1'b1, 64'h20, 1'b1, 64'h5555, 1'b1);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b00) begin n_err++; $display("FAIL rst_gnt got %b want 00", {imem_gnt, dmem_gnt}); end
    n_cmp++; if ({imem_err, dmem_err} !== 2'b00) begin n_err++; $display("FAIL rst_err got %b want 00", {imem_err, dmem_err}); end
    n_cmp++; if (imem_rdata !== 64'h0 || dmem_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rdata got %h/%h want 0/0", imem_rdata, dmem_rdata); end
    n_cmp++; if (arb_sel !== 1'b1) begin n_err++; $display("FAIL rst_arb_sel got %b want 1", arb_sel); end
  endtask

  task automatic test_single_imem();
    drv(1'b1, 1'b1, 64'h1000, 1'b0, 64'h2000, 1'b1, 64'h1234, 1'b0);
    n_cmp++; if (mem_addr !== 64'h1000) begin n_err++; $display("FAIL single_addr got %h want 1000", mem_addr); end
    n_cmp++; if (mem_req !== 1'b1 || mem_wen !== 1'b0) begin n_err++; $display("FAIL single_req_wen got %b%b want 10", mem_req, mem_wen); end
    n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b10) begin n_err++; $display("FAIL single_gnt got %b want 10", {imem_gnt, dmem_gnt}); end
    n_cmp++; if (imem_rdata !== 64'h0) begin n_err++; $display("FAIL single_early_rdata got %h want 0", imem_rdata); end
    drv(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'hDEADBEEF, 1'b0);
    n_cmp++; if (imem_rdata !== 64'hDEADBEEF) begin n_err++; $display("FAIL single_imem_rdata got %h want deadbeef", imem_rdata); end
    n_cmp++; if (dmem_rdata !== 64'h0) begin n_err++; $display("FAIL single_dmem_rdata got %h want 0", dmem_rdata); end
    idle();
    n_cmp++; if (imem_rdata !== 64'h0) begin n_err++; $display("FAIL single_rdata_clear got %h want 0", imem_rdata); end
  endtask

  task automatic test_both();
    drv(1'b1, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1, 64'h0, 1'b0);
    n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b01) begin n_err++; $display("FAIL both_gnt1 got %b want 01", {imem_gnt, dmem_gnt}); end
    n_cmp++; if (mem_addr !== 64'h2000 || mem_wen !== 1'b1 || mem_strb !== 8'hF0 || mem_wdata !== 64'hD0D0)
      begin n_err++; $display("FAIL both_fwd got %h %b %h %h want 2000 1 f0 d0d0", mem_addr, mem_wen, mem_strb, mem_wdata); end
    drv(1'b1, 1'b1, 64'h1000, 1'b0, 64'h0, 1'b1, 64'hAAAA, 1'b0);
    n_cmp++; if (dmem_rdata !== 64'hAAAA || imem_rdata !== 64'h0) begin n_err++; $display("FAIL both_resp1 got %h/%h want 0/aaaa", imem_rdata, dmem_rdata); end
    n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b10 || mem_addr !== 64'h1000) begin n_err++; $display("FAIL both_gnt2 got %b %h want 10 1000", {imem_gnt, dmem_gnt}, mem_addr); end
    drv(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'hBBBB, 1'b0);
    n_cmp++; if (imem_rdata !== 64'hBBBB || dmem_rdata !== 64'h0) begin n_err++; $display("FAIL both_resp2 got %h/%h want bbbb/0", imem_rdata, dmem_rdata); end
    idle();
  endtask

  task automatic test_lock();
    for (int c = 0; c < 3; c++) begin
      drv(1'b1, (c > 0), 64'h1100, 1'b1, 64'h3000, 1'b0, 64'h0, 1'b0);
      n_cmp++; if (arb_sel !== 1'b1 || mem_addr !== 64'h3000 || imem_gnt !== 1'b0 || dmem_gnt !== 1'b0)
        begin n_err++; $display("FAIL lock_dmem_hold c=%0d got sel=%b addr=%h gnt=%b%b want 1 3000 00", c, arb_sel, mem_addr, imem_gnt, dmem_gnt); end
    end
    drv(1'b1, 1'b1, 64'h1100, 1'b1, 64'h3000, 1'b1, 64'h0, 1'b0);
    n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b01) begin n_err++; $display("FAIL lock_dmem_accept got %b want 01", {imem_gnt, dmem_gnt}); end
    drv(1'b1, 1'b1, 64'h1100, 1'b0, 64'h0, 1'b1, 64'h0, 1'b0);
    n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b10) begin n_err++; $display("FAIL lock_imem_after got %b want 10", {imem_gnt, dmem_gnt}); end
    idle();
    // imem stalled alone, then the higher-priority dmem arrives: selection must stay on imem
    drv(1'b1, 1'b1, 64'h1200, 1'b0, 64'h3300, 1'b0, 64'h0, 1'b0);
    drv(1'b1, 1'b1, 64'h1200, 1'b1, 64'h3300, 1'b0, 64'h0, 1'b0);
    n_cmp++; if (arb_sel !== 1'b0 || mem_addr !== 64'h1200 || dmem_gnt !== 1'b0)
      begin n_err++; $display("FAIL lock_imem_hold got sel=%b addr=%h dgnt=%b want 0 1200 0", arb_sel, mem_addr, dmem_gnt); end
    drv(1'b1, 1'b1, 64'h1200, 1'b1, 64'h3300, 1'b1, 64'h0, 1'b0);
    n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b10) begin n_err++; $display("FAIL lock_imem_accept got %b want 10", {imem_gnt, dmem_gnt}); end
    idle();
  endtask

  task automatic test_lock_drop();
    drv(1'b1, 1'b1, 64'h9000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    n_cmp++; if (arb_sel !== 1'b0 || mem_req !== 1'b1) begin n_err++; $display("FAIL drop_pend got sel=%b req=%b want 0 1", arb_sel, mem_req); end
    drv(1'b1, 1'b0, 64'h0, 1'b1, 64'hA000, 1'b1, 64'h0, 1'b0);
    n_cmp++; if (arb_sel !== 1'b0 || mem_req !== 1'b0 || {imem_gnt, dmem_gnt} !== 2'b00)
      begin n_err++; $display("FAIL drop_cycle got sel=%b req=%b gnt=%b%b want 0 0 00", arb_sel, mem_req, imem_gnt, dmem_gnt); end
    drv(1'b1, 1'b0, 64'h0, 1'b1, 64'hA000, 1'b1, 64'h0, 1'b0);
    n_cmp++; if (arb_sel !== 1'b1 || dmem_gnt !== 1'b1 || mem_addr !== 64'hA000)
      begin n_err++; $display("FAIL drop_release got sel=%b dgnt=%b addr=%h want 1 1 a000", arb_sel, dmem_gnt, mem_addr); end
    idle();
    idle();
  endtask

  task automatic test_starve();
    logic exp_i, prev_i;
    prev_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1, 64'h100 + 64'(i), 1'b0);
      exp_i = (i == 4) || (i == 9);
      n_cmp++; if ({imem_gnt, dmem_gnt} !== {exp_i, ~exp_i})
        begin n_err++; $display("FAIL starve_gnt i=%0d got %b want %b", i, {imem_gnt, dmem_gnt}, {exp_i, ~exp_i}); end
      if (i > 0) begin
        n_cmp++;
        if ((prev_i ? imem_rdata : dmem_rdata) !== 64'h100 + 64'(i) || (prev_i ? dmem_rdata : imem_rdata) !== 64'h0)
          begin n_err++; $display("FAIL starve_resp i=%0d got i=%h d=%h want owner_imem=%b val=%h", i, imem_rdata, dmem_rdata, prev_i, 64'h100 + 64'(i)); end
      end
      prev_i = exp_i;
    end
    idle();
    idle();
  endtask

  task automatic test_err();
    drv(1'b1, 1'b0, 64'h0, 1'b1, 64'h4400, 1'b1, 64'h0, 1'b1);
    n_cmp++; if ({imem_err, dmem_err} !== 2'b00) begin n_err++; $display("FAIL err_early got %b want 00", {imem_err, dmem_err}); end
    drv(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    n_cmp++; if ({imem_err, dmem_err} !== 2'b01) begin n_err++; $display("FAIL err_resp got %b want 01", {imem_err, dmem_err}); end
    drv(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    n_cmp++; if ({imem_err, dmem_err} !== 2'b00) begin n_err++; $display("FAIL err_gated got %b want 00", {imem_err, dmem_err}); end
    idle();
  endtask

  task automatic test_reset_mid();
    drv(1'b1, 1'b0, 64'h0, 1'b1, 64'h4000, 1'b1, 64'h0, 1'b0);
    n_cmp++; if (dmem_gnt !== 1'b1) begin n_err++; $display("FAIL rmid_accept got %b want 1", dmem_gnt); end
    drv(1'b1, 1'b1, 64'h5000, 1'b0, 64'h0, 1'b0, 64'h4444, 1'b0);
    n_cmp++; if (dmem_rdata !== 64'h4444 || arb_sel !== 1'b0 || mem_req !== 1'b1)
      begin n_err++; $display("FAIL rmid_pend got rdata=%h sel=%b req=%b want 4444 0 1", dmem_rdata, arb_sel, mem_req); end
    drv(1'b0, 1'b1, 64'h5000, 1'b1, 64'h6000, 1'b1, 64'h7777, 1'b1);
    n_cmp++; if (mem_req !== 1'b0 || {imem_gnt, dmem_gnt} !== 2'b00 || {imem_err, dmem_err} !== 2'b00)
      begin n_err++; $display("FAIL rmid_forced got req=%b gnt=%b%b err=%b%b want 0 00 00", mem_req, imem_gnt, dmem_gnt, imem_err, dmem_err); end
    drv(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h8888, 1'b1);
    n_cmp++; if (arb_sel !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("FAIL rmid_release got sel=%b req=%b want 1 0", arb_sel, mem_req); end
    n_cmp++; if ({imem_err, dmem_err} !== 2'b00 || imem_rdata !== 64'h0 || dmem_rdata !== 64'h0)
      begin n_err++; $display("FAIL rmid_drop got err=%b%b rdata=%h/%h want 00 0/0", imem_err, dmem_err, imem_rdata, dmem_rdata); end
  endtask

  initial begin
    g_resetn = 1'b0;
    imem_req = 1'b0; imem_addr = '0; imem_wen = 1'b0; imem_strb = 8'h0F; imem_wdata = 64'hC0C0;
    dmem_req = 1'b0; dmem_addr = '0; dmem_wen = 1'b1; dmem_strb = 8'hF0; dmem_wdata = 64'hD0D0;
    mem_gnt = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_imem();
    test_both();
    test_lock();
    test_lock_drop();
    test_starve();
    test_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
